// File: rtl/snn_core_param.sv
// Two-layer binary-input spiking-style classifier core: a hidden MAC layer and an output MAC layer
// share one accumulator and one activation LUT, then an argmax picks the winning class.
module snn_core_param #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 32,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned ACC_W = 26
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(N_OUT)-1:0]               digit,
  output logic signed [7:0]                      max_val,
  output logic [$clog2(N_IN)-1:0]                in_addr,
  input  logic                                   in_bit,
  output logic [$clog2(N_HID)+$clog2(N_IN)-1:0]  hw_addr,
  input  logic signed [7:0]                      hw_q,
  output logic [$clog2(N_OUT)+$clog2(N_HID)-1:0] ow_addr,
  input  logic signed [7:0]                      ow_q,
  output logic [10:0]                            lut_addr,
  input  logic signed [7:0]                      lut_q
);

  localparam int unsigned IW = $clog2(N_IN);
  localparam int unsigned HW = $clog2(N_HID);
  localparam int unsigned OW = $clog2(N_OUT);
  localparam logic signed [ACC_W-1:0] SatHi = ACC_W'(1023);
  localparam logic signed [ACC_W-1:0] SatLo = ACC_W'(-1024);

  typedef enum logic [3:0] {
    StIdle, StHidMac, StHidDrain, StHidLut, StHidWr,
    StOutMac, StOutDrain, StOutLut, StOutCmp, StDone
  } state_e;

  state_e                  state_q;
  logic [IW-1:0]           i_q;
  logic [HW-1:0]           h_q;
  logic [HW-1:0]           j_q;
  logic [OW-1:0]           o_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    busy_q, done_q;
  logic [OW-1:0]           digit_q, best_idx_q;
  logic signed [7:0]       max_val_q, best_val_q;

  logic signed [7:0]       ram [N_HID];
  logic signed [7:0]       ram_rd_q;

  logic signed [7:0]       op1, op2;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sh;
  logic                    acc_en;

  assign busy     = busy_q;
  assign done     = done_q;
  assign digit    = digit_q;
  assign max_val  = max_val_q;
  assign in_addr  = i_q;
  assign hw_addr  = {h_q, i_q};
  assign ow_addr  = {o_q, j_q};

  // Memory data lags the address by one cycle, so index 0 of a MAC pass carries no product.
  always_comb begin
    op1    = 8'sd0;
    op2    = 8'sd0;
    acc_en = 1'b0;
    if (state_q == StHidMac || state_q == StHidDrain) begin
      op1    = in_bit ? 8'sd127 : 8'sd0;
      op2    = hw_q;
      acc_en = (state_q == StHidDrain) || (i_q != '0);
    end else if (state_q == StOutMac || state_q == StOutDrain) begin
      op1    = ram_rd_q;
      op2    = ow_q;
      acc_en = (state_q == StOutDrain) || (j_q != '0);
    end
    prod     = 16'(op1) * 16'(op2);
    prod_ext = ACC_W'(prod);
  end

  always_comb begin
    sh = acc_q >>> 7;
    if (sh > SatHi) begin
      lut_addr = 11'h7FF;
    end else if (sh < SatLo) begin
      lut_addr = 11'h000;
    end else begin
      lut_addr = {~sh[10], sh[9:0]};
    end
  end

  // Gated by rst_n so a reset landing on a write cycle cannot commit it.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == StHidWr) begin
      ram[h_q] <= lut_q;
    end
    ram_rd_q <= ram[j_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      i_q        <= '0;
      h_q        <= '0;
      j_q        <= '0;
      o_q        <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digit_q    <= '0;
      max_val_q  <= 8'sd0;
      best_idx_q <= '0;
      best_val_q <= 8'sd0;
    end else begin
      done_q <= 1'b0;
      if (acc_en) begin
        acc_q <= acc_q + prod_ext;
      end
      case (state_q)
        StIdle: begin
          busy_q <= start;
          if (start) begin
            state_q <= StHidMac;
          end
        end
        StHidMac: begin
          if (i_q == IW'(N_IN - 1)) begin
            i_q     <= '0;
            state_q <= StHidDrain;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        StHidDrain: state_q <= StHidLut;
        StHidLut:   state_q <= StHidWr;
        StHidWr: begin
          acc_q <= '0;
          if (h_q == HW'(N_HID - 1)) begin
            h_q     <= '0;
            state_q <= StOutMac;
          end else begin
            h_q     <= h_q + 1'b1;
            state_q <= StHidMac;
          end
        end
        StOutMac: begin
          if (j_q == HW'(N_HID - 1)) begin
            j_q     <= '0;
            state_q <= StOutDrain;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        StOutDrain: state_q <= StOutLut;
        StOutLut:   state_q <= StOutCmp;
        StOutCmp: begin
          acc_q <= '0;
          // Strictly-greater keeps the lowest index on ties.
          if (o_q == '0 || lut_q > best_val_q) begin
            best_val_q <= lut_q;
            best_idx_q <= o_q;
          end
          if (o_q == OW'(N_OUT - 1)) begin
            o_q     <= '0;
            state_q <= StDone;
          end else begin
            o_q     <= o_q + 1'b1;
            state_q <= StOutMac;
          end
        end
        StDone: begin
          digit_q   <= best_idx_q;
          max_val_q <= best_val_q;
          done_q    <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_core_param.sv
// Bench for snn_core_param: a small instance checked cycle-by-cycle against an arithmetic model,
// plus a default-size instance that exercises LUT-address saturation.
module tb_snn_core_param;

  localparam int NI = 4;
  localparam int NH = 2;
  localparam int NO = 3;
  localparam int HL = NH * (NI + 3);
  localparam int LAT = HL + NO * (NH + 3) + 1;
  localparam int B_IN = 784;
  localparam int B_LAT = 32 * (784 + 3) + 10 * (32 + 3) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Small instance
  logic              s_rst_n, s_start, s_busy, s_done, s_in_bit;
  logic [1:0]        s_digit, s_in_addr;
  logic signed [7:0] s_max_val, s_hw_q, s_ow_q, s_lut_q;
  logic [2:0]        s_hw_addr, s_ow_addr;
  logic [10:0]       s_lut_addr;

  snn_core_param #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .ACC_W(26)) u_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .digit(s_digit), .max_val(s_max_val), .in_addr(s_in_addr), .in_bit(s_in_bit),
    .hw_addr(s_hw_addr), .hw_q(s_hw_q), .ow_addr(s_ow_addr), .ow_q(s_ow_q),
    .lut_addr(s_lut_addr), .lut_q(s_lut_q)
  );

  logic              in_mem  [NI];
  logic signed [7:0] hw_mem  [8];
  logic signed [7:0] ow_mem  [8];
  logic signed [7:0] lut_mem [2048];

  always @(posedge clk) begin
    s_in_bit <= in_mem[s_in_addr];
    s_hw_q   <= hw_mem[s_hw_addr];
    s_ow_q   <= ow_mem[s_ow_addr];
    s_lut_q  <= lut_mem[s_lut_addr];
  end

  // Behavioural model
  int   m_cyc = -1;
  logic exp_busy = 1'b0, exp_done = 1'b0;
  int   exp_digit = 0, exp_max = 0, r_digit = 0, r_max = 0;
  int   hid_addr [NH];
  int   out_addr [NO];
  logic chk_en = 1'b0;

  function automatic int sat_addr(input int acc);
    int a, s;
    a = (acc <<< 6) >>> 6;
    s = a >>> 7;
    if (s > 1023) return 2047;
    if (s < -1024) return 0;
    return s + 1024;
  endfunction

  task automatic compute();
    int acc, oact;
    int hact [NH];
    for (int h = 0; h < NH; h++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) if (in_mem[i]) acc += 127 * int'(hw_mem[h*4+i]);
      hid_addr[h] = sat_addr(acc);
      hact[h] = int'(lut_mem[hid_addr[h]]);
    end
    for (int o = 0; o < NO; o++) begin
      acc = 0;
      for (int j = 0; j < NH; j++) acc += hact[j] * int'(ow_mem[o*2+j]);
      out_addr[o] = sat_addr(acc);
      oact = int'(lut_mem[out_addr[o]]);
      if (o == 0 || oact > r_max) begin
        r_max = oact;
        r_digit = o;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!s_rst_n) begin
      m_cyc = -1; exp_busy = 1'b0; exp_done = 1'b0; exp_digit = 0; exp_max = 0;
    end else begin
      exp_done = 1'b0;
      if (m_cyc >= 0) begin
        m_cyc++;
        if (m_cyc == LAT) begin
          exp_done = 1'b1; exp_digit = r_digit; exp_max = r_max;
        end else if (m_cyc > LAT) begin
          m_cyc = -1; exp_busy = 1'b0;
        end
      end
      if (m_cyc < 0 && s_start) begin
        m_cyc = 0; exp_busy = 1'b1;
        compute();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int k, u;
      chk("busy", s_busy, exp_busy);
      chk("done", s_done, exp_done);
      chk("digit", s_digit, exp_digit);
      chk("max_val", 32'(s_max_val), exp_max);
      if (m_cyc >= 0 && m_cyc < HL) begin
        u = m_cyc / (NI + 3); k = m_cyc % (NI + 3);
        if (k < NI) begin
          chk("in_addr", s_in_addr, k);
          chk("hw_addr", s_hw_addr, u * 4 + k);
        end else if (k == NI + 1) begin
          chk("hid_lut_addr", s_lut_addr, hid_addr[u]);
        end
      end else if (m_cyc >= HL && m_cyc < LAT - 1) begin
        u = (m_cyc - HL) / (NH + 3); k = (m_cyc - HL) % (NH + 3);
        if (k < NH) chk("ow_addr", s_ow_addr, u * 2 + k);
        else if (k == NH + 1) chk("out_lut_addr", s_lut_addr, out_addr[u]);
      end
    end
  end

  task automatic run(input int second_at, output int lat);
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    lat = 0;
    while (s_done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      s_start = (lat == second_at);
    end
    s_start = 1'b0;
  endtask

  task automatic finish_run(input string nm, input int lat, input int dg, input int mx);
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_digit"}, s_digit, dg);
    chk({nm, "_max_val"}, 32'(s_max_val), mx);
    chk({nm, "_busy_at_done"}, s_busy, 1);
    @(negedge clk);
    chk({nm, "_done_width"}, s_done, 0);
    chk({nm, "_busy_after"}, s_busy, 0);
  endtask

  // Default-size instance
  logic              b_rst_n, b_start, b_busy, b_done, b_in_bit;
  logic [3:0]        b_digit;
  logic signed [7:0] b_max_val, b_hw_q, b_ow_q, b_lut_q;
  logic [9:0]        b_in_addr;
  logic [14:0]       b_hw_addr;
  logic [8:0]        b_ow_addr;
  logic [10:0]       b_lut_addr;
  logic              big_fin = 1'b0;

  snn_core_param u_big (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .digit(b_digit), .max_val(b_max_val), .in_addr(b_in_addr), .in_bit(b_in_bit),
    .hw_addr(b_hw_addr), .hw_q(b_hw_q), .ow_addr(b_ow_addr), .ow_q(b_ow_q),
    .lut_addr(b_lut_addr), .lut_q(b_lut_q)
  );

  // Even hidden units see +127 weights, odd ones -128.
  always @(posedge clk) begin
    b_in_bit <= 1'b1;
    b_hw_q   <= b_hw_addr[10] ? 8'sh80 : 8'sh7F;
    b_ow_q   <= 8'sd0;
    b_lut_q  <= 8'sd0;
  end

  initial begin
    int cyc;
    b_rst_n = 1'b0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    cyc = 0;
    while (b_done !== 1'b1 && cyc < B_LAT + 10) begin
      if (cyc % (B_IN + 3) == B_IN + 1)
        chk("big_hid_lut_addr", b_lut_addr, ((cyc / (B_IN + 3)) % 2 != 0) ? 0 : 2047);
      @(negedge clk);
      cyc++;
    end
    chk("big_latency", cyc, B_LAT);
    chk("big_digit", b_digit, 0);
    chk("big_max_val", 32'(b_max_val), 0);
    big_fin = 1'b1;
  end

  initial begin
    int lat;
    s_rst_n = 1'b0; s_start = 1'b0;
    for (int i = 0; i < 2048; i++) lut_mem[i] = 8'sd0;
    for (int i = 0; i < 8; i++) begin
      hw_mem[i] = 8'(i * 7 - 20);
      ow_mem[i] = 8'sd5;
    end
    for (int i = 0; i < NI; i++) in_mem[i] = 1'b0;
    repeat (3) @(negedge clk);
    s_rst_n = 1'b1;
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_digit", s_digit, 0);
    chk("rst_max_val", 32'(s_max_val), 0);
    chk_en = 1'b1;

    // All-zero inputs with a zero LUT; a second start mid-run must be ignored.
    run(10, lat);
    finish_run("zero", lat, 0, 0);

    // Activations {5, 20, 20}: tie resolves to the lower index.
    lut_mem[11'h400] = 8'sd64;
    lut_mem[11'h401] = 8'sd5;
    lut_mem[11'h402] = 8'sd20;
    lut_mem[11'h403] = 8'sd20;
    ow_mem[0] = 8'sd1; ow_mem[1] = 8'sd1;
    ow_mem[2] = 8'sd2; ow_mem[3] = 8'sd2;
    ow_mem[4] = 8'sd3; ow_mem[5] = 8'sd3;
    run(0, lat);
    finish_run("tie", lat, 1, 20);

    // Activations {-3, -7, -1}.
    lut_mem[11'h401] = -8'sd3;
    lut_mem[11'h402] = -8'sd7;
    lut_mem[11'h403] = -8'sd1;
    run(0, lat);
    finish_run("neg", lat, 2, -1);

    // Mixed inputs: hidden addrs 0x42C / 0x38F, output addrs 0x400 / 0x3FE / 0x402.
    in_mem[0] = 1'b1; in_mem[1] = 1'b0; in_mem[2] = 1'b1; in_mem[3] = 1'b1;
    hw_mem[0] = 8'sd10;  hw_mem[1] = -8'sd20; hw_mem[2] = 8'sd30;  hw_mem[3] = 8'sd5;
    hw_mem[4] = -8'sd50; hw_mem[5] = 8'sd7;   hw_mem[6] = -8'sd60; hw_mem[7] = -8'sd3;
    ow_mem[0] = 8'sd3;  ow_mem[1] = 8'sd2;
    ow_mem[2] = -8'sd1; ow_mem[3] = 8'sd4;
    ow_mem[4] = 8'sd5;  ow_mem[5] = -8'sd6;
    lut_mem[11'h42C] = 8'sd40;
    lut_mem[11'h38F] = -8'sd25;
    lut_mem[11'h400] = 8'sd9;
    lut_mem[11'h3FE] = 8'sd33;
    lut_mem[11'h402] = -8'sd4;
    run(0, lat);
    finish_run("mixed", lat, 1, 33);

    // One-cycle reset during the first output MAC cycle aborts the run.
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    repeat (HL) @(negedge clk);
    s_rst_n = 1'b0;
    @(negedge clk) s_rst_n = 1'b1;
    chk("abort_busy", s_busy, 0);
    chk("abort_done", s_done, 0);
    chk("abort_digit", s_digit, 0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", s_busy, 0);
    run(0, lat);
    finish_run("rerun", lat, 1, 33);

    chk_en = 1'b0;
    while (!big_fin) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_core_param.md
SNN_CORE_PARAM -- requirements
Module: snn_core_param

Interface
- REQ-001 SHALL have parameter N_IN, default 784: input units per image.
- REQ-002 SHALL have parameter N_HID, default 32: hidden units.
- REQ-003 SHALL have parameter N_OUT, default 10: output units (classes).
- REQ-004 SHALL have parameter ACC_W, default 26: signed accumulator width.
- REQ-005 SHALL have port clk, in, 1: sole clock, rising edge.
- REQ-006 SHALL have port rst_n, in, 1: reset, synchronous, active-low.
- REQ-007 SHALL have port start, in, 1: request a classification.
- REQ-008 SHALL have port busy, out, 1: high from start acceptance until the done cycle, inclusive.
- REQ-009 SHALL have port done, out, 1: one-cycle completion pulse.
- REQ-010 SHALL have port digit, out, clog2(N_OUT): winning output index.
- REQ-011 SHALL have port max_val, out, 8: signed winning activation.
- REQ-012 SHALL have port in_addr, out, clog2(N_IN), and port in_bit, in, 1: input bitmap memory with 1-cycle read latency.
- REQ-013 SHALL have port hw_addr, out, clog2(N_HID)+clog2(N_IN) = {hidden idx, input idx}, and port hw_q, in, 8 signed: hidden weight ROM with 1-cycle latency.
- REQ-014 SHALL have port ow_addr, out, clog2(N_OUT)+clog2(N_HID) = {output idx, hidden idx}, and port ow_q, in, 8 signed: output weight ROM with 1-cycle latency.
- REQ-015 SHALL have port lut_addr, out, 11, and port lut_q, in, 8 signed: activation LUT with 1-cycle latency.

Function
- REQ-016 SHALL contain an internal N_HID x 8 hidden-activation RAM: synchronous write, 1-cycle read.
- REQ-017 SHALL implement states IDLE, HID_MAC, HID_DRAIN, HID_LUT, HID_WR, OUT_MAC, OUT_DRAIN, OUT_LUT, OUT_CMP, DONE.
- REQ-018 SHALL leave IDLE for HID_MAC only when start=1 is sampled; start in any other state is ignored.
- REQ-019 HID_MAC SHALL last N_IN cycles issuing in_addr/hw_addr input index 0..N_IN-1; each returned product is accumulated on the following cycle.
- REQ-020 Hidden-layer MAC operand 1 SHALL be 127 when in_bit=1, else 0; operand 2 SHALL be hw_q; the product is signed and sign-extended to ACC_W.
- REQ-021 HID_DRAIN (1 cycle) SHALL accumulate the last product.
- REQ-022 HID_LUT (1 cycle) SHALL drive lut_addr from the accumulator.
- REQ-023 HID_WR (1 cycle) SHALL write lut_q to RAM[h], clear the accumulator, and advance h; after h=N_HID-1 the next state is OUT_MAC, else HID_MAC.
- REQ-024 lut_addr SHALL be s + 1024, where s = acc>>>7 saturated to [-1024, 1023]; acc>>>7 > 1023 gives 0x7FF, acc>>>7 < -1024 gives 0x000.
- REQ-025 OUT_MAC/OUT_DRAIN/OUT_LUT SHALL mirror the hidden-layer sequence over N_HID cycles, with operand 1 = RAM[j] and operand 2 = ow_q.
- REQ-026 OUT_CMP SHALL compare lut_q (signed) with the running max: output 0 always loads; a later output loads only if strictly greater, so the lowest index wins ties.
- REQ-027 OUT_CMP SHALL clear the accumulator; after o=N_OUT-1 the next state is DONE, else OUT_MAC.
- REQ-028 DONE SHALL register digit and max_val, pulse done=1 for one cycle, then return to IDLE.
- REQ-029 done SHALL rise exactly N_HID*(N_IN+3) + N_OUT*(N_HID+3) + 1 cycles after the edge sampling start.
- REQ-030 digit and max_val SHALL hold between done pulses and update only in DONE.
- REQ-031 All counters SHALL wrap to 0 at layer boundaries; no address SHALL exceed N-1.
- REQ-032 The accumulator SHALL wrap modulo 2^ACC_W; no overflow detection is provided.

Reset
- REQ-033 On a clock edge with rst_n=0: state=IDLE, busy=0, done=0, digit=0, max_val=0, accumulator and all counters 0.
- REQ-034 Reset mid-operation SHALL abort the run with no further RAM writes; a new start after reset release SHALL run normally.
- REQ-035 Hidden RAM contents are undefined after reset and are fully rewritten by each run.

Verification
- REQ-036 N_IN=4, N_HID=2, N_OUT=3; start pulsed, and again mid-run -> done at exactly cycle 30, one cycle wide; second start ignored; busy high for cycles 0..30.
- REQ-037 All in_bit=0, LUT returns 0 at 0x400 -> every hidden and output lut_addr = 0x400; digit=0, max_val=0 (tie).
- REQ-038 Defaults, all in_bit=1, hw_q=127 -> hidden lut_addr=0x7FF; with hw_q=-128 -> hidden lut_addr=0x000.
- REQ-039 Output activations {5, 20, 20} -> digit=1, max_val=20; activations {-3, -7, -1} -> digit=2, max_val=-1.
- REQ-040 rst_n=0 for one cycle during OUT_MAC -> next cycle busy=0, done=0, digit=0; a subsequent start gives a correct result at the REQ-029 latency.
